// File: rtl/panic_sha_pkg.sv
// Shared definitions for the SHA result merge path: descriptor width, digest width, FSM states.
// `PANIC_DESC_WIDTH may be overridden on the command line; 128 otherwise.
`ifndef PANIC_DESC_WIDTH
`define PANIC_DESC_WIDTH 128
`endif

package panic_sha_pkg;

  localparam int unsigned DIGEST_WIDTH = 512;
  localparam int unsigned DIGEST_KEEP  = DIGEST_WIDTH / 8;
  localparam logic [15:0] BEAT_MAX     = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DESC   = 2'd1,
    DATA   = 2'd2,
    DIGEST = 2'd3
  } merge_state_t;

endpackage

// File: rtl/sha_merge_skid.sv
// Two-entry AXI-Stream register slice; upstream ready comes straight from a flop.
module sha_merge_skid #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int unsigned BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] main_beat;
  logic [BEAT_W-1:0] skid_beat;
  logic              main_valid;
  logic              skid_valid;

  assign in_beat                     = {s_tlast, s_tkeep, s_tdata};
  assign s_tready                    = !skid_valid;
  assign m_tvalid                    = main_valid;
  assign {m_tlast, m_tkeep, m_tdata} = main_beat;

  // The skid entry catches the beat accepted while the output was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_beat  <= '0;
      skid_beat  <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!skid_valid) begin
      if (!main_valid || m_tready) begin
        main_valid <= s_tvalid;
        main_beat  <= in_beat;
      end else if (s_tvalid) begin
        skid_valid <= 1'b1;
        skid_beat  <= in_beat;
      end
    end else if (m_tready) begin
      main_beat  <= skid_beat;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sha_result_merge.sv
// Merges descriptor, payload and SHA digest into one AXI-Stream packet.
// SHA_MERGE_OUTREG_EN: register the output through sha_merge_skid (+1 cycle latency).
module sha_result_merge
  import panic_sha_pkg::*;
#(
  parameter int unsigned SWITCH_DATA_WIDTH = 512,
  parameter int unsigned SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
  parameter int unsigned DESC_WIDTH        = `PANIC_DESC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DESC_WIDTH-1:0]        s_desc_tdata,
  input  logic                         s_desc_tvalid,
  output logic                         s_desc_tready,
  input  logic [DIGEST_WIDTH-1:0]      s_sha_tdata,
  input  logic                         s_sha_tvalid,
  output logic                         s_sha_tready,
  input  logic [SWITCH_DATA_WIDTH-1:0] s_data_tdata,
  input  logic [SWITCH_KEEP_WIDTH-1:0] s_data_tkeep,
  input  logic                         s_data_tvalid,
  output logic                         s_data_tready,
  input  logic                         s_data_tlast,
  output logic [SWITCH_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [SWITCH_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         pkt_done,
  output logic [15:0]                  pkt_beats
);

  merge_state_t                 state, state_next;
  logic [SWITCH_DATA_WIDTH-1:0] mux_tdata;
  logic [SWITCH_KEEP_WIDTH-1:0] mux_tkeep;
  logic                         mux_tvalid;
  logic                         mux_tready;
  logic                         mux_tlast;
  logic                         data_hs;
  logic                         digest_hs;
  logic [15:0]                  beat_cnt;

  assign data_hs   = (state == DATA)   && s_data_tvalid && mux_tready;
  assign digest_hs = (state == DIGEST) && s_sha_tvalid  && mux_tready;

  always_comb begin
    state_next    = state;
    mux_tdata     = '0;
    mux_tkeep     = '0;
    mux_tvalid    = 1'b0;
    mux_tlast     = 1'b0;
    s_desc_tready = 1'b0;
    s_data_tready = 1'b0;
    s_sha_tready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_desc_tvalid) state_next = DESC;
      end
      DESC: begin
        mux_tdata[DESC_WIDTH-1:0]   = s_desc_tdata;
        mux_tkeep[DESC_WIDTH/8-1:0] = '1;
        mux_tvalid                  = s_desc_tvalid;
        s_desc_tready               = mux_tready;
        if (s_desc_tvalid && mux_tready) state_next = DATA;
      end
      DATA: begin
        mux_tdata     = s_data_tdata;
        mux_tkeep     = s_data_tkeep;
        mux_tvalid    = s_data_tvalid;
        s_data_tready = mux_tready;
        if (data_hs && s_data_tlast) state_next = DIGEST;
      end
      DIGEST: begin
        mux_tdata[DIGEST_WIDTH-1:0] = s_sha_tdata;
        mux_tkeep[DIGEST_KEEP-1:0]  = '1;
        mux_tvalid                  = s_sha_tvalid;
        mux_tlast                   = 1'b1;
        s_sha_tready                = mux_tready;
        if (digest_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      pkt_beats <= '0;
      pkt_done  <= 1'b0;
    end else begin
      state    <= state_next;
      pkt_done <= digest_hs;
      if (data_hs && beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 16'd1;
      if (digest_hs) begin
        pkt_beats <= beat_cnt;
        beat_cnt  <= '0;
      end
    end
  end

`ifdef SHA_MERGE_OUTREG_EN
  sha_merge_skid #(
    .DATA_WIDTH (SWITCH_DATA_WIDTH),
    .KEEP_WIDTH (SWITCH_KEEP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (mux_tdata),
    .s_tkeep  (mux_tkeep),
    .s_tvalid (mux_tvalid),
    .s_tready (mux_tready),
    .s_tlast  (mux_tlast),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready),
    .m_tlast  (m_axis_tlast)
  );
`else
  assign m_axis_tdata  = mux_tdata;
  assign m_axis_tkeep  = mux_tkeep;
  assign m_axis_tvalid = mux_tvalid;
  assign m_axis_tlast  = mux_tlast;
  assign mux_tready    = m_axis_tready;
`endif

endmodule
